jstk_frame_decoder: RTL
=======================

// Module: jstk_frame_decoder
// PURPOSE
//  Consumes the byte stream from the joystick SPI controller and assembles each 5-byte frame.
//  Publishes X/Y position (10b raw, 11b centred signed) and button state to the display/game logic.
//  Checks frame length and reserved bits; holds the last good sample until the next good frame.
// PARAMETERS
//  NUM_BYTES      5        bytes per frame (X lo, X hi, Y lo, Y hi, buttons)
//  CENTER         512      subtracted from raw position to form x_off/y_off
//  TIMEOUT_CYCLES 1000000  max clk cycles between bytes in a frame before abort
// PORTS
//  clk          in   1   system clock, single domain
//  rst          in   1   asynchronous, active-low reset
//  frame_start  in   1   1-cycle strobe: slave select asserted, new transaction begins
//  byte_valid   in   1   1-cycle strobe: byte_in holds a received byte
//  byte_in      in   8   received byte, valid only with byte_valid
//  frame_end    in   1   1-cycle strobe: slave select released, transaction complete
//  x_pos        out  10  last good X, raw 0..1023
//  y_pos        out  10  last good Y, raw 0..1023
//  x_off        out  11  signed x_pos - CENTER
//  y_off        out  11  signed y_pos - CENTER
//  btn          out  3   {btn2, btn1, stick_btn} from byte 4 bits [2:0]
//  sample_valid out  1   1-cycle pulse: outputs just updated
//  frame_err    out  1   1-cycle pulse: frame discarded
//  busy         out  1   high while in COLLECT
// BEHAVIOUR
//  Reset (rst=0): all outputs 0; state IDLE; byte index 0; timeout counter 0; capture regs 0.
//  FSM IDLE -> COLLECT on frame_start; COLLECT -> CHECK on frame_end; CHECK -> IDLE next cycle.
//  IDLE: byte_valid and frame_end are ignored; no error raised.
//  COLLECT: each byte_valid stores byte_in at index idx (0..NUM_BYTES-1) and increments idx.
//   Timeout counter clears on every byte_valid and increments otherwise.
//  Overflow: byte_valid when idx==NUM_BYTES -> frame_err pulse, go to IDLE, outputs unchanged.
//  Timeout: counter reaches TIMEOUT_CYCLES in COLLECT -> frame_err pulse, go to IDLE.
//  Same-cycle byte_valid + frame_end: the byte is stored first; CHECK sees the updated idx.
//  frame_start in COLLECT or CHECK: restarts collection (idx=0, COLLECT); the partial frame is dropped.
//   This raises frame_err only if idx!=0. A frame being checked in CHECK still completes first.
//  CHECK: the frame is good iff idx==NUM_BYTES and b1[7:2]==0 and b3[7:2]==0.
//   Good frame:
//    x_pos={b1[1:0],b0}, y_pos={b3[1:0],b2}, btn=b4[2:0].
//    x_off/y_off = zero-extended raw minus CENTER, 11-bit two's complement (range -512..+511).
//    sample_valid pulses in the cycle after CHECK, coincident with updated outputs.
//    Latency is 2 clk from frame_end to sample_valid.
//   Bad frame: frame_err pulses in the same cycle slot; x/y/btn outputs hold their previous values.
//  sample_valid and frame_err are never asserted together; each is exactly 1 cycle wide.
//  Async reset mid-frame discards the partial frame; there is no output pulse on reset release.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE, COLLECT, CHECK), JSTK_NUM_BYTES,
//   byte-index constants (JSTK_XLO..JSTK_BTN), and button bit positions.
//  Sub-module: jstk_byte_buffer, a NUM_BYTES x 8 capture register file with write index,
//   clear, and overflow flag. All other logic stays in this module.
// TESTING
//  1 frame_start; bytes 0x34,0x02,0xFF,0x03,0x05; frame_end
//   -> x_pos=0x234, y_pos=0x3FF, x_off=+52, y_off=+511, btn=3'b101, one sample_valid 2 clk later.
//  2 Frame of only 4 bytes then frame_end -> frame_err pulse; outputs keep values from test 1.
//  3 Byte1=0x06 (reserved bit set) -> frame_err; 6th byte in a frame -> frame_err, IDLE, no sample_valid.
//  4 Last byte_valid coincident with frame_end -> accepted as good frame; bytes 0,0,0,0,0 give x_off=y_off=-512.
//  5 TIMEOUT_CYCLES=16, stall 16 cycles after byte 2 -> frame_err, busy drops; next full frame decodes normally.
//  6 Assert rst low mid-frame -> all outputs 0 immediately; no pulses after release; next frame decodes.

Source files
------------

// File: rtl/jstk_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jstk_frame_decoder_pkg
// Brief   : Shared encodings for the joystick frame decoder.
// Revision: 1.0 - initial release
// ============================================================================
package jstk_frame_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } jstk_state_t;

    localparam int JSTK_NUM_BYTES = 5;

    localparam int JSTK_XLO = 0;
    localparam int JSTK_XHI = 1;
    localparam int JSTK_YLO = 2;
    localparam int JSTK_YHI = 3;
    localparam int JSTK_BTN = 4;

    localparam int JSTK_BTN_STICK = 0;
    localparam int JSTK_BTN_1     = 1;
    localparam int JSTK_BTN_2     = 2;

    // High bytes carry only two position bits; the rest must be clear.
    function automatic logic jstk_rsvd_clear(input logic [7:0] b);
        return (b[7:2] == 6'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jstk_frame_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : jstk_frame_decoder_if
// Brief   : Byte-stream input and decoded-sample output bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface jstk_frame_decoder_if;
    logic               frame_start;
    logic               byte_valid;
    logic [7:0]         byte_in;
    logic               frame_end;
    logic [9:0]         x_pos;
    logic [9:0]         y_pos;
    logic signed [10:0] x_off;
    logic signed [10:0] y_off;
    logic [2:0]         btn;
    logic               sample_valid;
    logic               frame_err;
    logic               busy;

    modport master (
        output frame_start, byte_valid, byte_in, frame_end,
        input  x_pos, y_pos, x_off, y_off, btn, sample_valid, frame_err, busy
    );

    modport slave (
        input  frame_start, byte_valid, byte_in, frame_end,
        output x_pos, y_pos, x_off, y_off, btn, sample_valid, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/jstk_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module  : jstk_byte_buffer
// Brief   : NUM_BYTES x 8 capture registers with write index and overflow.
// Revision: 1.0 - initial release
// ============================================================================
module jstk_byte_buffer #(
    parameter int NUM_BYTES = 5
) (
    input  wire logic                               clk,
    input  wire logic                               rst,
    input  wire logic                               clr,
    input  wire logic                               wr_en,
    input  wire logic [7:0]                         wr_data,
    output logic      [NUM_BYTES-1:0][7:0]          data,
    output logic      [$clog2(NUM_BYTES+1)-1:0]     idx,
    output logic                                    full,
    output logic                                    ovf
);
    localparam int IDX_W = $clog2(NUM_BYTES + 1);

    logic [IDX_W-1:0] r_idx;

    assign idx  = r_idx;
    assign full = (r_idx == IDX_W'(NUM_BYTES));
    assign ovf  = wr_en & full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (clr) begin
            r_idx <= '0;
        end else if (wr_en && !full) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            logic [7:0] r_byte;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_byte <= 8'd0;
                end else if (clr) begin
                    r_byte <= 8'd0;
                end else if (wr_en && !full && (r_idx == IDX_W'(gi))) begin
                    r_byte <= wr_data;
                end
            end
            assign data[gi] = r_byte;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/jstk_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : jstk_frame_decoder
// Brief   : Assembles 5-byte joystick frames, validates, publishes X/Y/buttons.
// Revision: 1.0 - initial release
// ============================================================================
module jstk_frame_decoder
    import jstk_frame_decoder_pkg::*;
#(
    parameter int NUM_BYTES      = JSTK_NUM_BYTES,
    parameter int CENTER         = 512,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input wire logic           clk,
    input wire logic           rst,
    jstk_frame_decoder_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    jstk_state_t               r_state, w_next;
    logic [NUM_BYTES-1:0][7:0] w_bytes;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_full, w_ovf;
    logic                      w_clr, w_wr, w_err, w_load, w_good, w_timeout;
    logic [CNT_W-1:0]          r_cnt;
    logic [9:0]                w_x, w_y;
    logic [9:0]                r_x, r_y;
    logic [10:0]               r_xo, r_yo;
    logic [2:0]                r_btn;
    logic                      r_sv, r_err;

    jstk_byte_buffer #(.NUM_BYTES(NUM_BYTES)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .wr_en   (w_wr),
        .wr_data (bus.byte_in),
        .data    (w_bytes),
        .idx     (w_idx),
        .full    (w_full),
        .ovf     (w_ovf)
    );

    // A restart strobe wins over any byte arriving in the same cycle.
    assign w_wr      = (r_state == ST_COLLECT) && bus.byte_valid && !bus.frame_start;
    assign w_timeout = (r_state == ST_COLLECT) && (r_cnt >= CNT_W'(TIMEOUT_CYCLES));

    assign w_x    = {w_bytes[JSTK_XHI][1:0], w_bytes[JSTK_XLO]};
    assign w_y    = {w_bytes[JSTK_YHI][1:0], w_bytes[JSTK_YLO]};
    assign w_good = (w_idx == IDX_W'(NUM_BYTES)) &&
                    jstk_rsvd_clear(w_bytes[JSTK_XHI]) &&
                    jstk_rsvd_clear(w_bytes[JSTK_YHI]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_err  = 1'b0;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    w_clr  = 1'b1;
                    w_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.frame_start) begin
                    w_clr  = 1'b1;
                    w_err  = (w_idx != '0);
                    w_next = ST_COLLECT;
                end else if (w_ovf) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end else if (bus.frame_end) begin
                    w_next = ST_CHECK;
                end else if (!bus.byte_valid && w_timeout) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_load = 1'b1;
                w_next = ST_IDLE;
                if (bus.frame_start) begin
                    w_clr  = 1'b1;
                    w_next = ST_COLLECT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if ((r_state != ST_COLLECT) || bus.byte_valid || bus.frame_start) begin
            r_cnt <= '0;
        end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_xo  <= '0;
            r_yo  <= '0;
            r_btn <= '0;
            r_sv  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_sv  <= 1'b0;
            r_err <= w_err;
            if (w_load) begin
                if (w_good) begin
                    r_x   <= w_x;
                    r_y   <= w_y;
                    r_xo  <= {1'b0, w_x} - 11'(CENTER);
                    r_yo  <= {1'b0, w_y} - 11'(CENTER);
                    r_btn <= {w_bytes[JSTK_BTN][JSTK_BTN_2],
                              w_bytes[JSTK_BTN][JSTK_BTN_1],
                              w_bytes[JSTK_BTN][JSTK_BTN_STICK]};
                    r_sv  <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.x_pos        = r_x;
    assign bus.y_pos        = r_y;
    assign bus.x_off        = $signed(r_xo);
    assign bus.y_off        = $signed(r_yo);
    assign bus.btn          = r_btn;
    assign bus.sample_valid = r_sv;
    assign bus.frame_err    = r_err;
    assign bus.busy         = (r_state == ST_COLLECT);
endmodule
`default_nettype wire
